matrix_mem_responder: RTL

Word-addressed scratchpad memory that serves as the responder end of the matrix-engine memory bus (`mem_operation` / `addr` / `data` / `mem_opdone`). It holds the parameter words, operand matrices and result matrix used by the matrix accelerators, and answers each read or write with a single-cycle `mem_opdone` pulse after a programmable latency. A side host port lets the testbench or CPU preload operands and read back results.

---
 rtl/matrix_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder
//   Word-addressed 32-bit scratchpad that acts as the responder on the
//   matrix-engine memory bus. Each read or write is answered with a
//   single-cycle mem_opdone pulse LATENCY cycles after it is sampled.
//   A side host port preloads operands and reads back results.
//
// Optional feature: define MATRIX_MEM_BOUNDS_CHECK_EN to treat
//   addr_i >= DEPTH as out of range. Such reads return 0, such writes are
//   dropped, and err is set. Without it, the address wraps modulo DEPTH.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   mem_operation   00 none, 01 read, 11 write, 10 reserved (acked, sets err)
//   addr_i, data_i  word address / write data from the initiator
//   data_o          read data, held until the next read is sampled
//   mem_opdone      one-cycle completion pulse
//   busy            high while a request is in flight (WAIT/ACK)
//   err             sticky protocol/range error, cleared by reset only
//   host_we, host_addr, host_wdata, host_rdata   host side port
module matrix_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mem_operation,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   data_i,
    output logic [31:0]   data_o,
    output logic          mem_opdone,
    output logic          busy,
    output logic          err,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata
);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          oob;
    logic          bus_we;

    assign idx = addr_i[AW-1:0];

`ifdef MATRIX_MEM_BOUNDS_CHECK_EN
    assign oob = (addr_i >= 32'(DEPTH));
`else
    // Upper address bits are intentionally ignored: accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:AW];
    assign oob = 1'b0;
`endif

    // A bus write commits on its sampling edge, which only happens in IDLE.
    assign bus_we = !reset && (state == IDLE) && (mem_operation == OP_WRITE) && !oob;

    // Storage is never reset. The bus write is placed last so it wins a
    // same-word collision with the host on the same edge.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        if (bus_we) begin
            mem[idx] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            host_rdata <= '0;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            data_o     <= '0;
            mem_opdone <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_opdone <= 1'b0;
                    busy       <= 1'b0;
                    if (mem_operation != OP_NONE) begin
                        if (mem_operation == OP_READ) begin
                            data_o <= oob ? 32'd0 : mem[idx];
                        end
                        if ((mem_operation == OP_RSVD) || oob) begin
                            err <= 1'b1;
                        end
                        busy <= 1'b1;
                        cnt  <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state      <= ACK;
                            mem_opdone <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // The counter reaches zero on this edge: enter ACK now so
                    // the pulse lands LATENCY cycles after the sampling edge.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= ACK;
                        mem_opdone <= 1'b1;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    mem_opdone <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    mem_opdone <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
